// File: rtl/if_stage_bp_pkg.sv
// Shared types and constants for the branch-predicting fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Saturating step of a 2-bit direction counter toward the resolved outcome.
    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'b01);
        end
        return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/if_stage_bp_btb.sv
// Direct-mapped BTB with 2-bit direction counters; lookup by fetch PC, update from execute.
// Latency: lookup combinational; update lands on the next rising edge (read-before-write).
// Backpressure: none; updates are always accepted, regardless of fetch stalls.
module btb_2bit
    import if_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [XLEN-1:0]    tgt_mem [ENTRIES];
    ctr_t               ctr_mem [ENTRIES];

    logic [IDX_W-1:0] lidx;
    logic [TAG_W-1:0] ltag;
    logic             lhit;
    logic [IDX_W-1:0] uidx;
    logic [TAG_W-1:0] utag;
    logic             uhit;
    logic             alloc;

    // Word-aligned fetch: the two byte-offset bits never participate.
    logic unused_lo_bits;
    assign unused_lo_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup: index/tag split of the fetch PC, prediction from counter MSB.
    always_comb begin
        lidx        = lookup_pc[IDX_W+1:2];
        ltag        = lookup_pc[XLEN-1:IDX_W+2];
        lhit        = valid[lidx] && (tag_mem[lidx] == ltag);
        pred        = lhit && ctr_mem[lidx][1];
        pred_target = tgt_mem[lidx];
    end

    // Update decode: train an existing entry or allocate on a taken miss.
    always_comb begin
        uidx  = upd_pc[IDX_W+1:2];
        utag  = upd_pc[XLEN-1:IDX_W+2];
        uhit  = valid[uidx] && (tag_mem[uidx] == utag);
        alloc = upd_en && !uhit && upd_taken;
    end

    // Valid bits and counters: cleared to weakly-not-taken on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_mem[i] <= WNT;
            end
        end else if (upd_en) begin
            if (uhit) begin
                ctr_mem[uidx] <= ctr_step(ctr_mem[uidx], upd_taken);
            end else if (upd_taken) begin
                valid[uidx]   <= 1'b1;
                ctr_mem[uidx] <= WT;
            end
        end
    end

    // Tag and target payload: no reset needed, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (alloc) begin
                tag_mem[uidx] <= utag;
            end
            if (upd_en && upd_taken) begin
                tgt_mem[uidx] <= upd_target;
            end
        end
    end

endmodule

// File: rtl/if_stage_bp.sv
// Instruction fetch stage: PC register, BTB-predicted next PC, IF/ID pipeline register.
// Latency: instruction at imem_addr appears on *_D one cycle later; taken predictions redirect with no bubble.
// Backpressure: PCWrite=0 holds PC and IF/ID; a PCSrc_E redirect overrides the stall and flushes IF/ID.
module if_stage_bp
    import if_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              INSTR_W     = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               PCSrc_E,
    input  logic [XLEN-1:0]    PC_Target_E,
    input  logic               branch_resolved,
    input  logic               actual_taken,
    input  logic [XLEN-1:0]    branch_pc,
    input  logic [XLEN-1:0]    branch_target_resolved,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [XLEN-1:0]    PC_D,
    output logic [INSTR_W-1:0] instruction_D,
    output logic               pred_taken_D,
    output logic [XLEN-1:0]    pred_target_D,
    output logic               valid_D
);

    logic [XLEN-1:0] pc_f;
    logic            pred;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] npc;

    btb_2bit #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc_f),
        .pred        (pred),
        .pred_target (pred_target),
        .upd_en      (branch_resolved),
        .upd_taken   (actual_taken),
        .upd_pc      (branch_pc),
        .upd_target  (branch_target_resolved)
    );

    // Predicted next PC: BTB target on a taken prediction, else sequential.
    always_comb begin
        npc       = pred ? pred_target : pc_f + XLEN'(4);
        imem_addr = pc_f;
    end

    // PC register: redirect from execute beats a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (PCSrc_E) begin
            pc_f <= PC_Target_E;
        end else if (PCWrite) begin
            pc_f <= npc;
        end
    end

    // IF/ID register: flushed on reset or redirect, held on stall.
    always_ff @(posedge clk) begin
        if (reset || PCSrc_E) begin
            PC_D          <= '0;
            instruction_D <= INSTR_W'(NOP_INSTR);
            pred_taken_D  <= 1'b0;
            pred_target_D <= '0;
            valid_D       <= 1'b0;
        end else if (PCWrite) begin
            PC_D          <= pc_f;
            instruction_D <= imem_rdata;
            pred_taken_D  <= pred;
            pred_target_D <= npc;
            valid_D       <= 1'b1;
        end
    end

endmodule
